frame_scheduler: RTL and testbench

Sequences per-window processing for the autotune pipeline. Counts incoming mic samples into ping-pong analysis windows and launches YIN pitch detection on each completed window. Hands a validated tau to the PSOLA engine, starts it, and waits for its done. Sits between the sample path and the yin/psola blocks; detects overruns and pitch timeouts.

---
 rtl/frame_scheduler.sv | 160 ++++++++++++++++
 tb/tb_frame_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// Purpose: counts mic samples into ping-pong windows and sequences yin pitch detection then psola shifting per window.
// Latency: yin_start_out one cycle after the window-completing sample; psola_start_out one cycle after tau/timeout.
// Backpressure: none; windows completing while a frame is in flight are dropped and flagged as overrun.
module frame_scheduler #(
    parameter int WINDOW_SIZE    = 2048,
    parameter int TAUMAX         = 2048,
    parameter int TAU_W          = 11,
    parameter int DEFAULT_TAU    = 200,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_valid_in,
    input  logic                           clear_flags_in,
    output logic [$clog2(WINDOW_SIZE)-1:0] write_addr_out,
    output logic                           write_bank_out,
    output logic                           yin_start_out,
    output logic                           analysis_bank_out,
    input  logic [TAU_W-1:0]               tau_in,
    input  logic                           tau_valid_in,
    output logic                           psola_start_out,
    output logic [TAU_W-1:0]               psola_tau_out,
    input  logic                           psola_done_in,
    output logic [15:0]                    frame_count_out,
    output logic                           overrun_out,
    output logic                           timeout_out,
    output logic [1:0]                     state_out
);

    localparam int AW = $clog2(WINDOW_SIZE);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [AW-1:0]    LAST_ADDR   = AW'(WINDOW_SIZE - 1);
    localparam logic [CW-1:0]    TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [TAU_W:0]   TAUMAX_V    = (TAU_W + 1)'(TAUMAX);
    localparam logic [TAU_W-1:0] DEF_TAU_V   = TAU_W'(DEFAULT_TAU);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PITCH = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    wait_cnt;
    logic [TAU_W-1:0] last_tau;

    logic             frame_ready;
    logic             tau_ok;
    logic [TAU_W-1:0] next_tau;
    logic             pitch_expired;
    logic             overrun_set;
    logic             timeout_set;

    assign state_out = state;

    // A window completes on the sample written into the last address of the bank.
    assign frame_ready   = sample_valid_in && (write_addr_out == LAST_ADDR);

    // Only taus strictly inside (0, TAUMAX) replace the remembered estimate.
    assign tau_ok        = (tau_in != '0) && ({1'b0, tau_in} < TAUMAX_V);
    assign next_tau      = tau_ok ? tau_in : last_tau;

    assign pitch_expired = (state == ST_PITCH) && (wait_cnt == TO_LAST);

    // A completed window is dropped unless the scheduler is idle or is finishing its frame this very cycle.
    assign overrun_set   = frame_ready &&
                           ((state == ST_PITCH) || ((state == ST_SHIFT) && !psola_done_in));
    // A tau arriving on the last allowed cycle still counts as on time.
    assign timeout_set   = pitch_expired && !tau_valid_in;

    // Write side: sample address and bank toggle, independent of the frame FSM.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            write_addr_out <= '0;
            write_bank_out <= 1'b0;
        end else if (sample_valid_in) begin
            if (write_addr_out == LAST_ADDR) begin
                write_addr_out <= '0;
                write_bank_out <= ~write_bank_out;
            end else begin
                write_addr_out <= write_addr_out + AW'(1);
            end
        end
    end

    // Frame FSM: launches yin, collects tau (or times out), launches psola, waits for done.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= ST_IDLE;
            wait_cnt          <= '0;
            last_tau          <= DEF_TAU_V;
            psola_tau_out     <= DEF_TAU_V;
            yin_start_out     <= 1'b0;
            psola_start_out   <= 1'b0;
            analysis_bank_out <= 1'b0;
            frame_count_out   <= '0;
        end else begin
            yin_start_out   <= 1'b0;
            psola_start_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_ready) begin
                        state             <= ST_PITCH;
                        wait_cnt          <= '0;
                        yin_start_out     <= 1'b1;
                        analysis_bank_out <= write_bank_out;
                    end
                end
                ST_PITCH: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (tau_valid_in) begin
                        last_tau        <= next_tau;
                        psola_tau_out   <= next_tau;
                        psola_start_out <= 1'b1;
                        state           <= ST_SHIFT;
                    end else if (pitch_expired) begin
                        psola_tau_out   <= last_tau;
                        psola_start_out <= 1'b1;
                        state           <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (psola_done_in) begin
                        frame_count_out <= frame_count_out + 16'd1;
                        if (frame_ready) begin
                            state             <= ST_PITCH;
                            wait_cnt          <= '0;
                            yin_start_out     <= 1'b1;
                            analysis_bank_out <= write_bank_out;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            overrun_out <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun_out <= 1'b1;
            end else if (clear_flags_in) begin
                overrun_out <= 1'b0;
            end
            if (timeout_set) begin
                timeout_out <= 1'b1;
            end else if (clear_flags_in) begin
                timeout_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
module tb_frame_scheduler;

    localparam int WS = 16;
    localparam int TM = 2048;
    localparam int TW = 12;
    localparam int DT = 200;
    localparam int TO = 50;
    localparam int AW = $clog2(WS);

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          sample_valid_in;
    logic          clear_flags_in;
    logic [AW-1:0] write_addr_out;
    logic          write_bank_out;
    logic          yin_start_out;
    logic          analysis_bank_out;
    logic [TW-1:0] tau_in;
    logic          tau_valid_in;
    logic          psola_start_out;
    logic [TW-1:0] psola_tau_out;
    logic          psola_done_in;
    logic [15:0]   frame_count_out;
    logic          overrun_out;
    logic          timeout_out;
    logic [1:0]    state_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: sample total, frame phase (0 idle, 1 pitch, 2 shift), cycles spent waiting for pitch.
    int m_samples, m_phase, m_wait, m_last, m_ptau, m_frames, m_abank;
    bit m_yin, m_psola, m_ov, m_to;

    always #5 clk_in = ~clk_in;

    frame_scheduler #(
        .WINDOW_SIZE(WS), .TAUMAX(TM), .TAU_W(TW), .DEFAULT_TAU(DT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .sample_valid_in(sample_valid_in), .clear_flags_in(clear_flags_in),
        .write_addr_out(write_addr_out), .write_bank_out(write_bank_out),
        .yin_start_out(yin_start_out), .analysis_bank_out(analysis_bank_out),
        .tau_in(tau_in), .tau_valid_in(tau_valid_in),
        .psola_start_out(psola_start_out), .psola_tau_out(psola_tau_out),
        .psola_done_in(psola_done_in), .frame_count_out(frame_count_out),
        .overrun_out(overrun_out), .timeout_out(timeout_out), .state_out(state_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_samples = 0; m_phase = 0; m_wait = 0; m_last = DT; m_ptau = DT;
        m_frames = 0; m_abank = 0; m_yin = 0; m_psola = 0; m_ov = 0; m_to = 0;
    endtask

    // Advance the model across one clock edge given the inputs present before it.
    task automatic model_edge(input bit sv, input bit clr, input bit tv, input int tau, input bit done);
        bit fr, ov_ev, to_ev, start;
        fr = sv && ((m_samples % WS) == WS - 1);
        ov_ev = 0; to_ev = 0; start = 0;
        m_yin = 0; m_psola = 0;
        if (m_phase == 0) begin
            start = fr;
        end else if (m_phase == 1) begin
            m_wait++;
            if (tv) begin
                if (tau > 0 && tau < TM) m_last = tau;
                m_ptau = m_last; m_psola = 1; m_phase = 2;
            end else if (m_wait == TO) begin
                to_ev = 1; m_ptau = m_last; m_psola = 1; m_phase = 2;
            end
            ov_ev = fr;
        end else begin
            if (done) begin
                m_frames++;
                if (fr) start = 1; else m_phase = 0;
            end else begin
                ov_ev = fr;
            end
        end
        if (start) begin
            m_yin = 1; m_phase = 1; m_wait = 0;
            m_abank = (m_samples / WS) % 2;
        end
        if (sv) m_samples++;
        if (ov_ev) m_ov = 1; else if (clr) m_ov = 0;
        if (to_ev) m_to = 1; else if (clr) m_to = 0;
    endtask

    task automatic check_all();
        check("addr",   32'(write_addr_out),    32'(m_samples % WS));
        check("bank",   32'(write_bank_out),    32'((m_samples / WS) % 2));
        check("yin",    32'(yin_start_out),     32'(m_yin));
        check("psola",  32'(psola_start_out),   32'(m_psola));
        check("abank",  32'(analysis_bank_out), 32'(m_abank));
        check("ptau",   32'(psola_tau_out),     32'(m_ptau));
        check("frames", 32'(frame_count_out),   32'(m_frames % 65536));
        check("ovr",    32'(overrun_out),       32'(m_ov));
        check("tmo",    32'(timeout_out),       32'(m_to));
        check("state",  32'(state_out),         32'(m_phase));
        check("excl",   32'(yin_start_out & psola_start_out), 32'd0);
    endtask

    task automatic step(input bit sv, input bit clr, input bit tv, input int tau, input bit done);
        sample_valid_in = sv; clear_flags_in = clr; tau_valid_in = tv;
        tau_in = TW'(tau); psola_done_in = done;
        @(posedge clk_in);
        model_edge(sv, clr, tv, tau, done);
        #1;
        sample_valid_in = 0; clear_flags_in = 0; tau_valid_in = 0; tau_in = '0; psola_done_in = 0;
        check_all();
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(write_addr_out),    0);
        check({tag, "_bank"},  32'(write_bank_out),    0);
        check({tag, "_yin"},   32'(yin_start_out),     0);
        check({tag, "_psola"}, 32'(psola_start_out),   0);
        check({tag, "_abank"}, 32'(analysis_bank_out), 0);
        check({tag, "_ptau"},  32'(psola_tau_out),     DT);
        check({tag, "_frm"},   32'(frame_count_out),   0);
        check({tag, "_ovr"},   32'(overrun_out),       0);
        check({tag, "_tmo"},   32'(timeout_out),       0);
        check({tag, "_state"}, 32'(state_out),         0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tau_r;
        rst_in = 0; sample_valid_in = 0; clear_flags_in = 0;
        tau_valid_in = 0; tau_in = '0; psola_done_in = 0;
        model_reset();
        #23;
        check_reset_outputs("rst");
        @(posedge clk_in); #1;
        rst_in = 1;

        // Frame 1: window fill, yin launch, bad tau 0 with no prior estimate.
        feed(15);
        check("addr15", 32'(write_addr_out), 15);
        feed(1);
        check("f1_yin", 32'(yin_start_out), 1);
        check("f1_bank", 32'(write_bank_out), 1);
        check("f1_abank", 32'(analysis_bank_out), 0);
        check("f1_addr0", 32'(write_addr_out), 0);
        step(0, 0, 1, 0, 0);
        check("f1_ptau_def", 32'(psola_tau_out), DT);
        step(0, 0, 0, 0, 1);
        check("f1_frames", 32'(frame_count_out), 1);

        // Frame 2: good tau 350; frame 2 analyses bank 1.
        feed(16);
        check("f2_abank", 32'(analysis_bank_out), 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 350, 0);
        check("f2_psola", 32'(psola_start_out), 1);
        check("f2_ptau", 32'(psola_tau_out), 350);
        step(0, 0, 1, 77, 0);
        check("f2_tau_ignored", 32'(psola_tau_out), 350);
        step(0, 0, 0, 0, 1);
        check("f2_idle", 32'(state_out), 0);

        // Frame 3: out-of-range tau keeps previous good value.
        feed(16);
        step(0, 0, 1, 2048, 0);
        check("f3_ptau_keep", 32'(psola_tau_out), 350);
        step(0, 0, 0, 0, 1);

        // Frame 4: no tau -> timeout after TO pitch cycles, then clear.
        feed(16);
        for (int i = 0; i < TO + 5 && m_phase == 1; i++) step(0, 0, 0, 0, 0);
        check("f4_to_state", 32'(state_out), 2);
        check("f4_to_flag", 32'(timeout_out), 1);
        check("f4_to_ptau", 32'(psola_tau_out), 350);
        step(0, 1, 0, 0, 0);
        check("f4_to_clear", 32'(timeout_out), 0);
        step(0, 0, 0, 0, 1);

        // Frame 5: a whole window arrives during shift -> overrun, no extra yin.
        feed(16);
        step(0, 0, 1, 500, 0);
        feed(16);
        check("f5_ovr", 32'(overrun_out), 1);
        check("f5_noyin", 32'(yin_start_out), 0);
        step(0, 1, 0, 0, 1);
        check("f5_ovr_clr", 32'(overrun_out), 0);

        // Frame 6: window completes on the same cycle as psola done.
        feed(16);
        step(0, 0, 1, 123, 0);
        feed(15);
        step(1, 0, 0, 0, 1);
        check("f6_yin", 32'(yin_start_out), 1);
        check("f6_ovr", 32'(overrun_out), 0);
        check("f6_state", 32'(state_out), 1);

        // Asynchronous reset in the middle of pitch wait.
        feed(7);
        check("pre_rst_addr", 32'(write_addr_out), 7);
        #3;
        rst_in = 0;
        #1;
        check_reset_outputs("arst");
        @(posedge clk_in); #1;
        rst_in = 1;
        model_reset();
        check_all();

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       tau_r = 0;
                1:       tau_r = $urandom_range(TM, 4095);
                default: tau_r = $urandom_range(1, TM - 1);
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 15) == 0, tau_r, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
